// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-addressed data memory.
// Sub-word stores use a read-modify-write cycle so neighbouring lanes survive.
// Misaligned or reserved-size requests are answered with an error and never
// touch memory.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_load,
  input  logic                  req_store,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error
);

  typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  sign_q;
  logic                  store_q;
  logic [DATA_WIDTH-1:0] wdata_q;   // store data, later the merged write word
  logic [DATA_WIDTH-1:0] rdata_q;   // extended load result, 0 for stores/errors

  logic                  accept;
  logic                  bad;
  logic [7:0]            rd_b;
  logic [15:0]           rd_h;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] merged;

  // The response cycles also accept, giving back-to-back throughput.
  assign req_ready = (state == IDLE) || (state == DONE) || (state == ERR);
  assign accept    = req_valid & req_ready & (req_load | req_store);
  assign bad       = (req_size == 2'b11) ||
                     ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // All memory/response outputs decode only registered state.
  assign mem_read   = (state == RD);
  assign mem_write  = (state == WR);
  assign mem_addr   = {2'b00, addr_q[ADDR_WIDTH-1:2]};
  assign mem_wdata  = wdata_q;
  assign resp_valid = (state == DONE) || (state == ERR);
  assign resp_error = (state == ERR);
  assign resp_rdata = rdata_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: dispatch on accept, otherwise walk RD -> WR/DONE -> IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: begin
        state_nx = IDLE;
        if (accept) begin
          if (bad)                                     state_nx = ERR;
          else if (req_store && (req_size == 2'b10))   state_nx = WR;
          else                                         state_nx = RD;
        end
      end
      RD:      state_nx = store_q ? WR : DONE;
      WR:      state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane extraction from the word returned by memory, then extend or merge.
  always_comb begin
    rd_b   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    rd_h   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    merged = mem_rdata;
    case (size_q)
      2'b00: begin
        load_val = {{(DATA_WIDTH-8){sign_q & rd_b[7]}}, rd_b};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val = {{(DATA_WIDTH-16){sign_q & rd_h[15]}}, rd_h};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: load_val = mem_rdata;
    endcase
  end

  // Request capture on accept; read data consumed at the end of RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      store_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      size_q  <= req_size;
      sign_q  <= req_signed;
      store_q <= req_store;
      wdata_q <= req_wdata;
      rdata_q <= '0;
    end else if (state == RD) begin
      if (store_q) wdata_q <= merged;
      else         rdata_q <= load_val;
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit directly upstream of the word-addressed data memory. It takes byte/halfword/word load and store requests from the execute stage and converts them to word accesses.
- Loads: extracts the addressed lane and sign- or zero-extends it.
- Sub-word stores: performs a read-modify-write so that neighbouring bytes are preserved.
- Flags misaligned or reserved-size accesses without touching memory.

Parameters:
- ADDR_WIDTH, 32, width of byte address and of the memory word-index port
- DATA_WIDTH, 32, data width; fixed at 32 (4 little-endian byte lanes)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept a request
- req_load  in  1  load request
- req_store  in  1  store request; wins over req_load if both are high
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  loads: 1 sign-extends, 0 zero-extends
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- mem_addr  out  ADDR_WIDTH  word index = {2'b00, addr[ADDR_WIDTH-1:2]}
- mem_wdata  out  DATA_WIDTH  full word to write
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_rdata  in  DATA_WIDTH  memory read data, updated by memory on negedge clk
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  extended load result, valid with resp_valid
- resp_error  out  1  misaligned/reserved access, valid with resp_valid

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - Outputs: req_ready=1, all other outputs 0, including the internal address/data/size registers.
- Handshake:
  - A request is accepted at a posedge when req_valid & req_ready & (req_load | req_store).
  - req_valid with neither load nor store is ignored.
  - Requests while req_ready=0 are ignored; upstream must hold them.
- All mem_* and resp_* outputs are registered from state (no combinational path from req_* to mem_*).
- States and timing (cycle 1 = the cycle after acceptance):
  - IDLE: req_ready=1.
    - Misaligned or size 11 → ERR.
    - Load or sub-word store → RD.
    - Word store → WR.
  - RD (1 cycle): mem_read=1, mem_addr valid. The memory fills mem_rdata at the mid-cycle negedge; the unit captures it at the closing posedge.
    - Load → DONE.
    - Store → WR.
  - WR (1 cycle): mem_write=1, mem_addr and mem_wdata valid.
    - Word store: mem_wdata = req_wdata.
    - Sub-word store: captured word with the addressed lane(s) replaced.
    - Next: DONE.
  - DONE (1 cycle): resp_valid=1, resp_error=0. resp_rdata = extended load result; 0 for stores. Next: IDLE.
  - ERR (1 cycle): resp_valid=1, resp_error=1, resp_rdata=0, no mem_read/mem_write. Next: IDLE.
- Latency (request accepted at posedge t0; response in cycle):
  - load: resp_valid in cycle 2
  - word store: cycle 2
  - sub-word store: cycle 3
  - error: cycle 1
- Throughput: the next request can be accepted on the posedge that ends the resp_valid cycle.
- Lanes, little-endian:
  - Byte k = bits [8k+7:8k], k = addr[1:0].
  - Half: addr[1]=0 → [15:0], addr[1]=1 → [31:16].
- Misaligned:
  - Half with addr[0]=1.
  - Word with addr[1:0]≠0.
- Store data: byte uses req_wdata[7:0]; half uses req_wdata[15:0]; upper bits are ignored.
- mem_read and mem_write are never high in the same cycle.
- Reset mid-operation:
  - Any state → IDLE immediately.
  - mem_write/mem_read drop asynchronously.
  - No write is issued after reset releases.
  - No resp_valid is issued for the aborted request.

Test Plan (memory word 0x10 = 0x8899AABB, timings from acceptance posedge):
- LB signed, addr 0x11 → mem_read in cycle 1 with mem_addr=0x4; resp_valid in cycle 2 with resp_rdata=0xFFFFFFAA, resp_error=0. LBU at same addr → 0x000000AA.
- LH signed, addr 0x12 → resp_rdata=0xFFFF8899. LW addr 0x10 → 0x8899AABB, cycle 2.
- SB addr 0x12, wdata 0xDEADBE55:
  - mem_read in cycle 1.
  - mem_write in cycle 2 with mem_wdata=0x8855AABB.
  - resp_valid in cycle 3.
  - Subsequent LW 0x10 returns 0x8855AABB.
- SW addr 0x14, wdata 0x12345678 → no mem_read; mem_write in cycle 1 with mem_addr=0x5; resp_valid in cycle 2.
- LH addr 0x13, LW addr 0x12, and size=11 → resp_valid=1 and resp_error=1 in cycle 1; mem_read and mem_write stay 0. Load+store both high → treated as store.
- Reset cases:
  - SH addr 0x10 with rst_n low during the RD cycle → mem_read falls immediately; no mem_write or resp_valid after release; word 0x10 unchanged.
  - req_valid held while req_ready=0 → accepted only once, after DONE.
